// File: rtl/axi_lite_pkg.sv
// ============================================================================
// axi_lite_pkg : shared AXI4-Lite constants and read FSM state type
// Revision     : 1.0
// ============================================================================
`default_nettype none

package axi_lite_pkg;

  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_lite_regbank.sv
// ============================================================================
// axi_lite_regbank : NUM_REGS x 32-bit register bank, local write port
//                    and combinational read port. Revision 1.0
// ============================================================================
`default_nettype none

module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                      NUM_REGS    = 8,
  parameter logic [AXI_DATA_W-1:0]   REG_RST_VAL = '0,
  localparam int                     IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [AXI_DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [AXI_DATA_W-1:0] rd_data_o
);

  logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= REG_RST_VAL;
      end
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read sees the pre-write contents during a same-edge write.
  assign rd_data_o = regs_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/axi_lite_read_slave.sv
// ============================================================================
// axi_lite_read_slave : AXI4-Lite AR/R responder backed by a local register
//                       bank. Revision 1.0
// ============================================================================
`default_nettype none

module axi_lite_read_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_W      = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]     BASE_ADDR   = '0,
  parameter logic [AXI_DATA_W-1:0] REG_RST_VAL = '0,
  localparam int                   IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [AXI_DATA_W-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [AXI_DATA_W-1:0] wr_data,
  output logic [15:0]           rd_count
);

  localparam logic [ADDR_W-1:0] BANK_BYTES = ADDR_W'(NUM_REGS * 4);

  rd_state_t             state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [15:0]           rd_count_q, rd_count_d;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic [ADDR_W-1:0]     w_offset;
  logic                  w_misaligned;
  logic                  w_in_range;
  logic [AXI_DATA_W-1:0] w_bank_data;

  assign w_ar_hs      = ARVALID && arready_q;
  assign w_r_hs       = rvalid_q && RREADY;
  // Addresses below BASE_ADDR wrap to a large offset and fail the range test.
  assign w_offset     = ARADDR - BASE_ADDR;
  assign w_misaligned = (ARADDR[1:0] != 2'b00);
  assign w_in_range   = (w_offset < BANK_BYTES);

  axi_lite_regbank #(
    .NUM_REGS    (NUM_REGS),
    .REG_RST_VAL (REG_RST_VAL)
  ) u_regbank (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .rd_idx_i  (w_offset[IDX_W+1:2]),
    .rd_data_o (w_bank_data)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_count_q <= rd_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_count_d = rd_count_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (w_ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = RESP;
          if (w_misaligned) begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end else if (!w_in_range) begin
            rresp_d = RESP_DECERR;
            rdata_d = '0;
          end else begin
            rresp_d = RESP_OKAY;
            rdata_d = w_bank_data;
          end
        end
      end
      RESP: begin
        if (w_r_hs) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_count_d = rd_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign rd_count = rd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_read_slave.sv
// ============================================================================
// tb_axi_lite_read_slave : directed stimulus with a queue-based R-channel
//                          scoreboard. Revision 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_read_slave;

  logic        clk = 1'b0;
  logic        ARESET;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [15:0] rd_count;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  axi_lite_read_slave #(
    .ADDR_W      (32),
    .NUM_REGS    (8),
    .BASE_ADDR   (32'h0000_0000),
    .REG_RST_VAL (32'h0000_0000)
  ) dut (
    .ACLK     (clk),
    .ARESET   (ARESET),
    .ARADDR   (ARADDR),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: the R handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!ARESET && RVALID && RREADY) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL r_unexpected: got data %h resp %0d with no pending read", RDATA, RRESP);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (RDATA !== e.d || RRESP !== e.r) begin
          n_err++;
          $display("FAIL r_beat: got data %h resp %0d expected data %h resp %0d",
                   RDATA, RRESP, e.d, e.r);
        end
      end
    end
  end

  task automatic local_write(input logic [2:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_ar_hs();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ARREADY) begin ok = 1'b1; break; end
    end
    if (!ok) check("ar_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdelay,
                         input logic [31:0] ed, input logic [1:0] er,
                         input bit coll, input logic [2:0] cidx, input logic [31:0] cdata);
    bit ok = 1'b0;
    @(posedge clk); #1;
    ARADDR = addr; ARVALID = 1'b1; RREADY = (rdelay == 0);
    if (coll) begin wr_en = 1'b1; wr_idx = cidx; wr_data = cdata; end
    sb_q.push_back('{ed, er});
    wait_ar_hs();
    @(posedge clk); #1;
    ARVALID = 1'b0; wr_en = 1'b0;
    check("rvalid_latency", {31'd0, RVALID}, 32'd1);
    check("arready_busy", {31'd0, ARREADY}, 32'd0);
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      check("bp_rvalid", {31'd0, RVALID}, 32'd1);
      check("bp_rdata", RDATA, ed);
      check("bp_rresp", {30'd0, RRESP}, {30'd0, er});
      check("bp_arready", {31'd0, ARREADY}, 32'd0);
    end
    if (rdelay > 0) begin
      @(posedge clk); #1;
      RREADY = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (RVALID && RREADY) begin ok = 1'b1; break; end
    end
    if (!ok) check("r_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    RREADY = 1'b0;
    exp_cnt++;
    check("rvalid_drop", {31'd0, RVALID}, 32'd0);
    check("arready_back", {31'd0, ARREADY}, 32'd1);
    check("rd_count", {16'd0, rd_count}, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;

    // Reset state and ARREADY rising on the first edge after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", {31'd0, ARREADY}, 32'd0);
    check("rst_rvalid", {31'd0, RVALID}, 32'd0);
    check("rst_count", {16'd0, rd_count}, 32'd0);
    @(posedge clk); #1;
    ARESET = 1'b0;
    @(negedge clk);
    check("arready_pre_edge", {31'd0, ARREADY}, 32'd0);
    @(posedge clk); #1;
    check("arready_post_edge", {31'd0, ARREADY}, 32'd1);

    // Basic read
    local_write(3'd3, 32'hDEAD_BEEF);
    do_read(32'h0C, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 3'd0, 32'd0);

    // Backpressure
    local_write(3'd0, 32'h1234_5678);
    do_read(32'h00, 5, 32'h1234_5678, 2'b00, 1'b0, 3'd0, 32'd0);

    // Error responses and boundaries
    do_read(32'h06, 0, 32'h0, 2'b10, 1'b0, 3'd0, 32'd0);
    do_read(32'h20, 0, 32'h0, 2'b11, 1'b0, 3'd0, 32'd0);
    do_read(32'h21, 0, 32'h0, 2'b10, 1'b0, 3'd0, 32'd0);
    do_read(32'h1C, 0, 32'h0, 2'b00, 1'b0, 3'd0, 32'd0);
    do_read(32'hFFFF_FFFC, 0, 32'h0, 2'b11, 1'b0, 3'd0, 32'd0);

    // Write/read collision on the same edge
    local_write(3'd2, 32'hAAAA_AAAA);
    do_read(32'h08, 0, 32'hAAAA_AAAA, 2'b00, 1'b1, 3'd2, 32'h5555_5555);
    do_read(32'h08, 0, 32'h5555_5555, 2'b00, 1'b0, 3'd0, 32'd0);

    // Reset while a response is pending
    @(posedge clk); #1;
    ARADDR = 32'h0C; ARVALID = 1'b1; RREADY = 1'b0;
    wait_ar_hs();
    @(posedge clk); #1;
    ARVALID = 1'b0;
    check("mid_rvalid_set", {31'd0, RVALID}, 32'd1);
    @(negedge clk); #2;
    ARESET = 1'b1;
    #1;
    check("mid_rvalid_async", {31'd0, RVALID}, 32'd0);
    check("mid_arready_async", {31'd0, ARREADY}, 32'd0);
    check("mid_count_async", {16'd0, rd_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    ARESET = 1'b0;
    exp_cnt = 0;
    do_read(32'h0C, 0, 32'h0, 2'b00, 1'b0, 3'd0, 32'd0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
